// File: rtl/alu_ctrl_md.sv
// ALU control decoder with an extended op set, plus a sequencer for multi-cycle
// multiply/divide: launch pulse, busy tracking, HI/LO write strobe and decode stall.
module alu_ctrl_md #(
  parameter int CTRL_W     = 4,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_i,
  input  logic [2:0]        aluop_i,
  input  logic [5:0]        funct_i,
  output logic [CTRL_W-1:0] alu_ctrl_o,
  output logic              illegal_o,
  output logic              md_start_o,
  output logic [1:0]        md_op_o,
  output logic              md_busy_o,
  output logic              hilo_we_o,
  output logic [1:0]        hilo_rd_o,
  output logic              stall_o
);

  localparam int MAX_N = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W = $clog2(MAX_N + 1);

  localparam logic [3:0] C_ADD = 4'h0, C_SUB = 4'h1, C_AND = 4'h2, C_OR  = 4'h3,
                         C_XOR = 4'h4, C_SLT = 4'h5, C_NOR = 4'h6, C_SLTU = 4'h7,
                         C_SLL = 4'h8, C_SRL = 4'h9, C_SRA = 4'hA, C_LUI = 4'hB;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t           state_q, state_d;
  logic [CTRL_W-1:0] unused_w;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic             start_q, start_d;
  logic [3:0]       code4;
  logic             invalid;
  logic             is_r, is_md, is_mfhi, is_mflo, accept;

  assign unused_w = '0;

  always_comb begin
    code4   = C_ADD;
    invalid = 1'b0;
    case (aluop_i)
      3'b000: code4 = C_ADD;
      3'b001: code4 = C_SUB;
      3'b011: code4 = C_AND;
      3'b100: code4 = C_OR;
      3'b101: code4 = C_SLT;
      3'b110: code4 = C_LUI;
      3'b010: begin
        case (funct_i)
          6'b100000, 6'b100001: code4 = C_ADD;
          6'b100010, 6'b100011: code4 = C_SUB;
          6'b100100: code4 = C_AND;
          6'b100101: code4 = C_OR;
          6'b100110: code4 = C_XOR;
          6'b100111: code4 = C_NOR;
          6'b101010: code4 = C_SLT;
          6'b101011: code4 = C_SLTU;
          6'b000000: code4 = C_SLL;
          6'b000010: code4 = C_SRL;
          6'b000011: code4 = C_SRA;
          // mul/div and HI/LO moves pass through the ALU as a harmless add
          6'b011000, 6'b011001, 6'b011010, 6'b011011,
          6'b010000, 6'b010010: code4 = C_ADD;
          default: invalid = 1'b1;
        endcase
      end
      default: invalid = 1'b1;
    endcase
  end

  assign alu_ctrl_o = invalid ? {CTRL_W{1'b1}} : (unused_w | CTRL_W'(code4));
  assign illegal_o  = valid_i & invalid;

  assign is_r    = (aluop_i == 3'b010);
  assign is_md   = is_r & (funct_i[5:2] == 4'b0110);
  assign is_mfhi = is_r & (funct_i == 6'b010000);
  assign is_mflo = is_r & (funct_i == 6'b010010);

  assign hilo_rd_o  = valid_i ? {is_mflo, is_mfhi} : 2'b00;
  assign md_busy_o  = (state_q == S_BUSY);
  assign stall_o    = valid_i & md_busy_o & (is_md | is_mfhi | is_mflo);
  assign accept     = valid_i & is_md & ~stall_o;
  assign hilo_we_o  = md_busy_o & (cnt_q == CNT_W'(1));
  assign md_start_o = start_q;
  assign md_op_o    = op_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    start_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_BUSY;
          cnt_d   = funct_i[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
          op_d    = funct_i[1:0];
          start_d = 1'b1;
        end
      end
      S_BUSY: begin
        // cnt_q counts remaining busy cycles including the current one
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= 2'b00;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      start_q <= start_d;
    end
  end

endmodule
